ldpc_enc_rr_scheduler: RTL and testbench
========================================

// Module: ldpc_enc_rr_scheduler
// PURPOSE
//  Shares one bit-serial CCSDS (8176,7154) LDPC encoder between N_CH bit-serial AXI-Stream sources.
//  - Arbitration: round-robin, with the grant held for one whole codeblock (K info bits in, N code bits out).
//  - Output: the encoded stream, tagged with the source channel index.
//  - Placement: between the framing front-ends and the single encoder instance.
// PARAMETERS
//  N_CH   4     number of requesting channels (2..16)
//  K      7154  info bits per codeblock
//  N      8176  code bits per codeblock
//  CH_W   $clog2(N_CH) (localparam) channel-index width
// PORTS
//  clk                in   1     system clock
//  rst                in   1     asynchronous reset, active-high; also drives the encoder reset (rst_n = ~rst)
//  s_axis_tdata       in   N_CH  bit per channel
//  s_axis_tvalid      in   N_CH  per-channel valid
//  s_axis_tready      out  N_CH  per-channel ready
//  enc_s_tdata        out  1     to encoder input
//  enc_s_tvalid       out  1     to encoder input
//  enc_s_tready       in   1     from encoder input
//  enc_m_tdata        in   1     from encoder output
//  enc_m_tvalid       in   1     from encoder output
//  enc_m_tlast        in   1     from encoder output
//  enc_m_tready       out  1     to encoder output
//  m_axis_tdata       out  1     code bit
//  m_axis_tvalid      out  1     code bit valid
//  m_axis_tlast       out  1     last code bit of the block
//  m_axis_tuser       out  CH_W  channel index of the current block
//  m_axis_tready      in   1     downstream ready
//  busy               out  1     high whenever state != IDLE
//  err_len            out  1     sticky: enc_m_tlast seen with out_cnt != N-1
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, grant=0, rr_ptr=0, in_cnt=0, out_cnt=0.
//   - All outputs 0; m_axis_tuser=0.
//  FSM IDLE -> FEED -> DRAIN -> IDLE.
//  IDLE
//   - All s_axis_tready=0.
//   - If any s_axis_tvalid: register grant = first valid channel at or after rr_ptr (wrapping). Next cycle state=FEED.
//   - No valid: stay in IDLE.
//  FEED
//   - enc_s_* is driven from the granted channel, combinationally. s_axis_tready[grant] = enc_s_tready; all other readies are 0.
//   - in_cnt counts enc_s handshakes. On the handshake with in_cnt==K-1: in_cnt<=0 and state<=DRAIN.
//  Output path (FEED and DRAIN)
//   - m_axis_tdata/tvalid/tlast = enc_m_*; enc_m_tready = m_axis_tready; m_axis_tuser = grant.
//   - This is a pure pass-through: zero added latency, no buffering.
//   - out_cnt counts m_axis handshakes.
//  IDLE output gating: m_axis_tvalid=0 and enc_m_tready=0.
//  DRAIN
//   - enc_s_tvalid=0.
//   - On the m_axis handshake with enc_m_tlast=1: out_cnt<=0, rr_ptr<=grant+1 (wraps N_CH-1 -> 0), state<=IDLE.
//   - If out_cnt != N-1 at that handshake, err_len is set.
//  Grant stability
//   - The grant never changes inside a block; a deasserted tvalid on the granted channel stalls the encoder and does not release the grant.
//   - The granted channel's tvalid is not re-sampled for arbitration until IDLE.
//  Throughput: one IDLE cycle between blocks; back-to-back blocks are separated by exactly one arbitration cycle.
//  Reset mid-block
//   - Block is discarded; all state returns to reset values on the next edge.
//   - The encoder is reset in the same cycle. After release, arbitration restarts from rr_ptr=0.
// CONFIGURATION
//  LDPC_SCHED_STATS_EN
//   - Defined: adds output port blk_cnt[15:0], the number of completed blocks. It increments on each DRAIN->IDLE transition, wraps at 16 bits, and resets to 0.
//   - Undefined: the port and the counter are absent; all other behaviour is identical.
// STRUCTURE
//  Package ldpc_sched_pkg: K/N constants, state enum {IDLE,FEED,DRAIN} (one-hot), counter width 13.
//  Sub-module ldpc_rr_arb: combinational round-robin pick (req[N_CH], ptr) -> (gnt_idx, any).
//  Top level: FSM, counters and muxing.
// TESTING
//  1. ch0 only, 7154 zero bits, tready=1 -> 8176 zero bits out, tuser=0, tlast only on bit 8176, busy drops after it.
//  2. ch1 and ch2 continuously valid -> block order 1,2,1,2; tuser is constant within each block; no switch mid-block.
//  3. m_axis_tready random 50%, source tvalid random 70% -> bitstream equals the golden-model codeword; err_len=0.
//  4. rr_ptr=0 after ch3 was served; ch0 and ch3 valid -> ch0 granted next.
//  5. rst pulsed at in_cnt=3000 -> all outputs 0 on the next cycle. After release, ch2 valid -> new block from bit 0, tuser=2.
//  6. LDPC_SCHED_STATS_EN, 3 blocks -> blk_cnt==3; encoder stub with early tlast -> err_len=1 and stays set.

Source files
------------

// File: rtl/ldpc_sched_pkg.sv
// rtl/ldpc_sched_pkg.sv - shared constants for the LDPC encoder round-robin scheduler
package ldpc_sched_pkg;

    localparam int K_DEF = 7154;
    localparam int N_DEF = 8176;
    localparam int CNT_W = 13;

    localparam logic [2:0] ST_IDLE  = 3'b001;
    localparam logic [2:0] ST_FEED  = 3'b010;
    localparam logic [2:0] ST_DRAIN = 3'b100;

endpackage

// File: rtl/ldpc_rr_arb.sv
// rtl/ldpc_rr_arb.sv - combinational round-robin pick of the first request at or after ptr
module ldpc_rr_arb #(
    parameter int N_CH = 4,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] gnt_idx,
    output logic            any
);

    logic found;

    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            int j;
            j = (int'(ptr) + i) % N_CH;
            if (!found && req[j]) begin
                gnt_idx = CH_W'(j);
                found   = 1'b1;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/ldpc_enc_rr_scheduler.sv
// rtl/ldpc_enc_rr_scheduler.sv - shares one bit-serial LDPC encoder among N_CH sources, grant held per codeblock
// Optional block counter output blk_cnt enabled by LDPC_SCHED_STATS_EN.
module ldpc_enc_rr_scheduler
    import ldpc_sched_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int K    = K_DEF,
    parameter int N    = N_DEF,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] s_axis_tdata,
    input  logic [N_CH-1:0] s_axis_tvalid,
    output logic [N_CH-1:0] s_axis_tready,
    output logic            enc_s_tdata,
    output logic            enc_s_tvalid,
    input  logic            enc_s_tready,
    input  logic            enc_m_tdata,
    input  logic            enc_m_tvalid,
    input  logic            enc_m_tlast,
    output logic            enc_m_tready,
    output logic            m_axis_tdata,
    output logic            m_axis_tvalid,
    output logic            m_axis_tlast,
    output logic [CH_W-1:0] m_axis_tuser,
    input  logic            m_axis_tready,
`ifdef LDPC_SCHED_STATS_EN
    output logic [15:0]     blk_cnt,
`endif
    output logic            busy,
    output logic            err_len
);

    logic [2:0]       state_q, state_d;
    logic [CH_W-1:0]  grant_q, grant_d;
    logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             err_len_q, err_len_d;

    logic [CH_W-1:0]  arb_idx;
    logic             arb_any;
    logic             out_act, in_hs, out_hs, blk_done;

    ldpc_rr_arb #(.N_CH(N_CH)) u_arb (
        .req     (s_axis_tvalid),
        .ptr     (rr_ptr_q),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // Output path is a straight wire to the encoder, gated only while idle.
    always_comb begin
        out_act       = (state_q != ST_IDLE);
        s_axis_tready = '0;
        enc_s_tdata   = 1'b0;
        enc_s_tvalid  = 1'b0;
        if (state_q == ST_FEED) begin
            s_axis_tready[grant_q] = enc_s_tready;
            enc_s_tdata            = s_axis_tdata[grant_q];
            enc_s_tvalid           = s_axis_tvalid[grant_q];
        end
        m_axis_tdata  = out_act & enc_m_tdata;
        m_axis_tvalid = out_act & enc_m_tvalid;
        m_axis_tlast  = out_act & enc_m_tlast;
        enc_m_tready  = out_act & m_axis_tready;
        m_axis_tuser  = grant_q;
        busy          = out_act;
        err_len       = err_len_q;
        in_hs         = enc_s_tvalid & enc_s_tready;
        out_hs        = m_axis_tvalid & m_axis_tready;
        blk_done      = (state_q == ST_DRAIN) & out_hs & enc_m_tlast;
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_hs ? out_cnt_q + 1'b1 : out_cnt_q;
        err_len_d = err_len_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    grant_d = arb_idx;
                    state_d = ST_FEED;
                end
            end
            ST_FEED: begin
                if (in_hs) begin
                    if (in_cnt_q == CNT_W'(K - 1)) begin
                        in_cnt_d = '0;
                        state_d  = ST_DRAIN;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (blk_done) begin
                    out_cnt_d = '0;
                    rr_ptr_d  = (grant_q == CH_W'(N_CH - 1)) ? '0 : grant_q + 1'b1;
                    state_d   = ST_IDLE;
                    if (out_cnt_q != CNT_W'(N - 1)) err_len_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            err_len_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            err_len_q <= err_len_d;
        end
    end

`ifdef LDPC_SCHED_STATS_EN
    logic [15:0] blk_cnt_q, blk_cnt_d;

    always_comb begin
        blk_cnt_d = blk_done ? blk_cnt_q + 16'd1 : blk_cnt_q;
        blk_cnt   = blk_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) blk_cnt_q <= '0;
        else     blk_cnt_q <= blk_cnt_d;
    end
`endif

endmodule

// File: tb/tb_ldpc_enc_rr_scheduler.sv
// tb/tb_ldpc_enc_rr_scheduler.sv - directed bench for ldpc_enc_rr_scheduler with a small systematic encoder stub
module tb_ldpc_enc_rr_scheduler;

    localparam int NCH = 4;
    localparam int KK  = 6;
    localparam int NN  = 9;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] s_axis_tdata, s_axis_tvalid, s_axis_tready;
    logic           enc_s_tdata, enc_s_tvalid, enc_s_tready;
    logic           enc_m_tdata, enc_m_tvalid, enc_m_tlast, enc_m_tready;
    logic           m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [1:0]     m_axis_tuser;
    logic           busy, err_len;
`ifdef LDPC_SCHED_STATS_EN
    logic [15:0]    blk_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    int             src_cnt[NCH];
    int             exp_idx[NCH];
    logic [NCH-1:0] src_en;
    int             vprob, rprob;
    logic           zero_data, early;

    logic [KK-1:0]  ebuf;
    int             ecnt, ocnt;
    logic           emitting;

    logic [NN-1:0]  cur_bits;
    int             cur_len, cur_user;
    logic           cur_uok;
    int             q_user[$];
    int             q_len[$];
    logic [NN-1:0]  q_cw[$];
    logic           q_uok[$];
    int             blk_since_rst;

    ldpc_enc_rr_scheduler #(.N_CH(NCH), .K(KK), .N(NN)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .enc_s_tdata   (enc_s_tdata),
        .enc_s_tvalid  (enc_s_tvalid),
        .enc_s_tready  (enc_s_tready),
        .enc_m_tdata   (enc_m_tdata),
        .enc_m_tvalid  (enc_m_tvalid),
        .enc_m_tlast   (enc_m_tlast),
        .enc_m_tready  (enc_m_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready),
`ifdef LDPC_SCHED_STATS_EN
        .blk_cnt       (blk_cnt),
`endif
        .busy          (busy),
        .err_len       (err_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic info_bit(input int c, input int n);
        logic [7:0] h;
        h = 8'(c * 29 + n * 13 + (n >> 1));
        return zero_data ? 1'b0 : (h[3] ^ h[0]);
    endfunction

    function automatic logic code_bit(input logic [KK-1:0] info, input int j);
        logic [KK-1:0] m;
        if (j < KK) return info[j];
        case (j - KK)
            0:       m = 6'b010111;
            1:       m = 6'b101101;
            default: m = 6'b110011;
        endcase
        return ^(info & m);
    endfunction

    function automatic logic [NN-1:0] golden(input int c, input int start);
        logic [KK-1:0] info;
        logic [NN-1:0] cw;
        for (int i = 0; i < KK; i++) info[i] = info_bit(c, start + i);
        for (int j = 0; j < NN; j++) cw[j] = code_bit(info, j);
        return cw;
    endfunction

    task automatic reset_models();
        for (int c = 0; c < NCH; c++) begin
            src_cnt[c] = 0;
            exp_idx[c] = 0;
        end
        ecnt = 0; ocnt = 0; emitting = 1'b0;
        cur_len = 0; cur_user = 0; cur_uok = 1'b1; cur_bits = '0;
        q_user.delete(); q_len.delete(); q_cw.delete(); q_uok.delete();
        blk_since_rst = 0;
    endtask

    task automatic drive();
        for (int c = 0; c < NCH; c++) begin
            s_axis_tvalid[c] = src_en[c] && (int'($urandom_range(99)) < vprob);
            s_axis_tdata[c]  = info_bit(c, src_cnt[c]);
        end
        m_axis_tready = int'($urandom_range(99)) < rprob;
        enc_s_tready  = !emitting;
        enc_m_tvalid  = emitting;
        enc_m_tdata   = emitting && code_bit(ebuf, ocnt);
        enc_m_tlast   = emitting && (ocnt == (early ? NN - 3 : NN - 1));
    endtask

    task automatic tick();
        logic [NCH-1:0] s_hs;
        logic e_in_hs, e_out_hs, m_hs, m_bit, m_last, e_bit, e_last;
        int   m_user;
        s_hs     = s_axis_tvalid & s_axis_tready;
        e_in_hs  = enc_s_tvalid & enc_s_tready;
        e_out_hs = enc_m_tvalid & enc_m_tready;
        m_hs     = m_axis_tvalid & m_axis_tready;
        m_bit = m_axis_tdata; m_last = m_axis_tlast; m_user = int'(m_axis_tuser);
        e_bit = enc_s_tdata;  e_last = enc_m_tlast;
        @(posedge clk);
        #1;
        if (rst) begin
            reset_models();
        end else begin
            for (int c = 0; c < NCH; c++) if (s_hs[c]) src_cnt[c]++;
            if (e_in_hs) begin
                ebuf[ecnt] = e_bit;
                ecnt++;
                if (ecnt == KK) begin emitting = 1'b1; ocnt = 0; end
            end else if (e_out_hs) begin
                if (e_last) begin emitting = 1'b0; ecnt = 0; end
                else ocnt++;
            end
            if (m_hs) begin
                if (cur_len < NN) cur_bits[cur_len] = m_bit;
                if (cur_len == 0) cur_user = m_user;
                else if (m_user != cur_user) cur_uok = 1'b0;
                cur_len++;
                if (m_last) begin
                    q_user.push_back(cur_user); q_len.push_back(cur_len);
                    q_cw.push_back(cur_bits);   q_uok.push_back(cur_uok);
                    blk_since_rst++;
                    cur_len = 0; cur_uok = 1'b1; cur_bits = '0;
                end
            end
        end
        drive();
        #1;
    endtask

    task automatic set_src(input logic [NCH-1:0] mask);
        src_en = mask;
        drive();
        #1;
    endtask

    task automatic wait_blk(input string tag, input int n, input int budget);
        int t = 0;
        while (q_user.size() < n && t < budget) begin
            tick();
            t++;
        end
        if (q_user.size() < n) chk({tag, "_timeout"}, 64'(q_user.size()), 64'(n));
    endtask

    task automatic check_blk(input string tag, input int exp_ch);
        if (q_user.size() == 0) begin
            chk({tag, "_present"}, 0, 1);
            return;
        end
        chk({tag, "_tuser"},  64'(q_user[0]), 64'(exp_ch));
        chk({tag, "_len"},    64'(q_len[0]),  64'(NN));
        chk({tag, "_bits"},   64'(q_cw[0]),   64'(golden(exp_ch, exp_idx[exp_ch] * KK)));
        chk({tag, "_user_stable"}, 64'(q_uok[0]), 64'(1));
        exp_idx[exp_ch]++;
        void'(q_user.pop_front()); void'(q_len.pop_front());
        void'(q_cw.pop_front());   void'(q_uok.pop_front());
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},    64'(busy),          0);
        chk({tag, "_s_rdy"},   64'(s_axis_tready), 0);
        chk({tag, "_enc_sv"},  64'(enc_s_tvalid),  0);
        chk({tag, "_enc_mr"},  64'(enc_m_tready),  0);
        chk({tag, "_m_valid"}, 64'(m_axis_tvalid), 0);
        chk({tag, "_m_data"},  64'(m_axis_tdata),  0);
        chk({tag, "_m_last"},  64'(m_axis_tlast),  0);
        chk({tag, "_m_user"},  64'(m_axis_tuser),  0);
    endtask

    initial begin
        int t;
        rst = 1'b1; src_en = '0; vprob = 100; rprob = 100;
        zero_data = 1'b1; early = 1'b0; ebuf = '0;
        reset_models();
        drive();
        tick(); tick();
        set_src(4'b0001);
        check_idle_outputs("reset");
        chk("reset_err_len", 64'(err_len), 0);
        rst = 1'b0;
        drive(); #1;

        // 1: single channel, all-zero info bits
        wait_blk("t1", 1, 500);
        set_src(4'b0000);
        chk("t1_busy_drop", 64'(busy), 0);
        check_blk("t1", 0);
        tick();
        chk("t1_idle_hold", 64'(busy), 0);

        // 2: two contenders alternate block by block
        zero_data = 1'b0;
        set_src(4'b0110);
        wait_blk("t2", 4, 2000);
        set_src(4'b0000);
        check_blk("t2_b0", 1);
        check_blk("t2_b1", 2);
        check_blk("t2_b2", 1);
        check_blk("t2_b3", 2);

        // 3: random source stalls and downstream backpressure
        vprob = 70; rprob = 50;
        set_src(4'b1000);
        wait_blk("t3", 2, 4000);
        vprob = 100; rprob = 100;
        set_src(4'b1001);
        check_blk("t3_b0", 3);
        check_blk("t3_b1", 3);
        chk("t3_err_len", 64'(err_len), 0);

        // 4: pointer wrapped to 0 after ch3, so ch0 wins over ch3
        wait_blk("t4", 1, 500);
        set_src(4'b0000);
        check_blk("t4", 0);

        // 5: reset in the middle of a block
        set_src(4'b0100);
        t = 0;
        while (src_cnt[2] < 3 && t < 500) begin tick(); t++; end
        chk("t5_reach_mid", 64'(src_cnt[2] >= 3), 1);
        rst = 1'b1;
        #1;
        check_idle_outputs("t5_async");
        tick(); tick();
        rst = 1'b0;
        drive(); #1;
        wait_blk("t5", 1, 500);
        set_src(4'b0000);
        check_blk("t5", 2);

        // 6: early tlast from the encoder sets the sticky length error
        chk("t6_err_before", 64'(err_len), 0);
        early = 1'b1;
        set_src(4'b0010);
        wait_blk("t6_early", 1, 500);
        set_src(4'b0000);
        chk("t6_early_len", 64'(q_len[0]), 64'(NN - 2));
        chk("t6_early_tuser", 64'(q_user[0]), 1);
        chk("t6_err_set", 64'(err_len), 1);
        void'(q_user.pop_front()); void'(q_len.pop_front());
        void'(q_cw.pop_front());   void'(q_uok.pop_front());
        exp_idx[1]++;
        early = 1'b0;
        set_src(4'b0010);
        wait_blk("t6_norm", 1, 500);
        set_src(4'b0000);
        check_blk("t6_norm", 1);
        chk("t6_err_sticky", 64'(err_len), 1);
`ifdef LDPC_SCHED_STATS_EN
        chk("t6_blk_cnt", 64'(blk_cnt), 64'(blk_since_rst));
        chk("t6_blk_cnt_3", 64'(blk_cnt), 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
